// File: rtl/stripe_scheduler.sv
// Job sequencer for a striped alignment PE array: loads one 64-base stripe of B,
// streams gene A through the array, collects each stripe result and tracks the job-wide best.
module stripe_scheduler #(
   parameter int NUM_STRIPES = 16,
   parameter int SEQ_LEN     = 1024,
   parameter int FLUSH_MAX   = 128
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_go,
   output logic         o_busy,
   output logic         o_done,
   output logic [3:0]   o_b_addr,
   input  logic [127:0] i_b_row,
   output logic [9:0]   o_a_addr,
   input  logic [1:0]   i_a_data,
   output logic         o_start,
   output logic [1:0]   o_A,
   output logic [127:0] o_B,
   input  logic         i_stripe_end,
   input  logic [9:0]   i_start_position,
   input  logic [9:0]   i_end_position,
   input  logic [13:0]  i_max_score_stripe,
   output logic         o_res_valid,
   output logic [3:0]   o_res_stripe,
   output logic [9:0]   o_res_end_pos,
   output logic [13:0]  o_res_score,
   output logic         o_res_timeout,
   output logic [13:0]  o_best_score,
   output logic [3:0]   o_best_stripe,
   output logic [9:0]   o_best_end_pos
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_B = 3'd1;
   localparam logic [2:0] S_WAIT_B = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [9:0] LAST_A      = 10'(SEQ_LEN - 1);
   localparam logic [3:0] LAST_STRIPE = 4'(NUM_STRIPES - 1);
   localparam int         FW          = $clog2(FLUSH_MAX + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_MAX - 1);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [9:0]    base;
   logic [9:0]    a_ptr;
   logic [3:0]    stripe;
   logic [FW-1:0] flush_cnt;
   logic [9:0]    cap_start;
   logic          pe_end;
   logic          flush_timeout;
   logic [10:0]   base_sum;
   logic [9:0]    base_adv;

   // The PE's stripe_end only means something while A is being fed or drained.
   assign pe_end        = i_stripe_end && (state == S_STREAM || state == S_FLUSH);
   assign flush_timeout = (state == S_FLUSH) && !i_stripe_end && (flush_cnt == FLUSH_LAST);

   assign base_sum = {1'b0, base} + {1'b0, cap_start};
   assign base_adv = (base_sum > {1'b0, LAST_A}) ? LAST_A : base_sum[9:0];

   // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_go) state_nxt = S_LOAD_B;
         S_LOAD_B: state_nxt = S_WAIT_B;
         S_WAIT_B: state_nxt = S_STREAM;
         S_STREAM: begin
            if (i_stripe_end)        state_nxt = S_REPORT;
            else if (a_ptr == LAST_A) state_nxt = S_FLUSH;
         end
         S_FLUSH:  if (i_stripe_end || flush_cnt == FLUSH_LAST) state_nxt = S_REPORT;
         S_REPORT: state_nxt = (stripe == LAST_STRIPE) ? S_DONE : S_LOAD_B;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         o_start   <= 1'b0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         o_start   <= (state == S_STREAM) && !i_stripe_end;
         flush_cnt <= (state == S_FLUSH) ? flush_cnt + FW'(1) : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         base   <= '0;
         stripe <= '0;
         a_ptr  <= '0;
         o_B    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_go) begin
                  base   <= '0;
                  stripe <= '0;
               end
            end
            S_WAIT_B: begin
               o_B   <= i_b_row;
               a_ptr <= base;
            end
            S_STREAM: begin
               if (!i_stripe_end && a_ptr != LAST_A) a_ptr <= a_ptr + 10'd1;
            end
            S_REPORT: begin
               // A timed-out stripe gives no start position, so the next stripe reuses this base.
               if (!o_res_timeout)         base   <= base_adv;
               if (stripe != LAST_STRIPE)  stripe <= stripe + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_res_valid   <= 1'b0;
         o_res_stripe  <= '0;
         o_res_end_pos <= '0;
         o_res_score   <= '0;
         o_res_timeout <= 1'b0;
         cap_start     <= '0;
      end else begin
         o_res_valid <= pe_end || flush_timeout;
         if (pe_end) begin
            o_res_stripe  <= stripe;
            o_res_end_pos <= base + i_end_position;
            o_res_score   <= i_max_score_stripe;
            o_res_timeout <= 1'b0;
            cap_start     <= i_start_position;
         end else if (flush_timeout) begin
            o_res_stripe  <= stripe;
            o_res_end_pos <= LAST_A;
            o_res_score   <= '0;
            o_res_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_best_score   <= '0;
         o_best_stripe  <= '0;
         o_best_end_pos <= '0;
      end else if (state == S_IDLE && i_go) begin
         o_best_score   <= '0;
         o_best_stripe  <= '0;
         o_best_end_pos <= '0;
      end else if (state == S_REPORT && o_res_score > o_best_score) begin
         // Strict compare: on a tie the earlier stripe stays the best.
         o_best_score   <= o_res_score;
         o_best_stripe  <= o_res_stripe;
         o_best_end_pos <= o_res_end_pos;
      end
   end

   assign o_busy   = (state != S_IDLE);
   assign o_done   = (state == S_DONE);
   assign o_b_addr = stripe;
   assign o_a_addr = a_ptr;
   assign o_A      = o_start ? i_a_data : 2'b00;

endmodule

// File: doc/stripe_scheduler.md
STRIPE_SCHEDULER -- requirements
Module: stripe_scheduler

Interface
REQ-001 SHALL have parameter NUM_STRIPES, default 16; number of 64-base stripes of gene B per job.
REQ-002 SHALL have parameter SEQ_LEN, default 1024; length of gene A in bases.
REQ-003 SHALL have parameter FLUSH_MAX, default 128; cycles to wait for stripe_end after the last A base.
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_go  input  1  single-cycle job start pulse.
REQ-007 SHALL have port o_busy  output  1  job in progress.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse at job completion.
REQ-009 SHALL have port o_b_addr  output  4  stripe row address to B memory; 1-cycle read latency.
REQ-010 SHALL have port i_b_row  input  128  64 bases of B; base n at bits [2n+1:2n].
REQ-011 SHALL have port o_a_addr  output  10  A memory address; 1-cycle read latency.
REQ-012 SHALL have port i_a_data  input  2  A base read from o_a_addr of the previous cycle.
REQ-013 SHALL have port o_start  output  1  to PE array: o_A valid, stripe active.
REQ-014 SHALL have port o_A  output  2  to PE array: current A base.
REQ-015 SHALL have port o_B  output  128  to PE array: latched stripe of B; stable during a stripe.
REQ-016 SHALL have ports i_stripe_end (1), i_start_position (10), i_end_position (10), i_max_score_stripe (14)  inputs  from PE array; positions relative to the stripe base.
REQ-017 SHALL have ports o_res_valid (1), o_res_stripe (4), o_res_end_pos (10), o_res_score (14), o_res_timeout (1)  outputs  per-stripe result.
REQ-018 SHALL have ports o_best_score (14), o_best_stripe (4), o_best_end_pos (10)  outputs  job-wide best.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_B, WAIT_B, STREAM, FLUSH, REPORT, DONE.
REQ-020 SHALL move IDLE->LOAD_B on i_go; it SHALL ignore i_go in every other state.
REQ-021 SHALL clear base (10 b), stripe counter and best registers on the IDLE->LOAD_B transition.
REQ-022 SHALL drive o_b_addr=stripe in LOAD_B, latch i_b_row into o_B in WAIT_B, then enter STREAM; o_start SHALL be 0 in both states, giving at least 2 idle cycles between stripes.
REQ-023 SHALL, in STREAM, issue o_a_addr=a_ptr starting at base and increment it by 1 per cycle; o_start SHALL be registered 1 in the cycle after each address issue, with o_A=i_a_data.
REQ-024 SHALL on i_stripe_end=1 (STREAM or FLUSH) drive o_start=0 next cycle, capture the PE result, and enter REPORT.
REQ-025 SHALL enter FLUSH with o_start=0 after issuing address SEQ_LEN-1 without i_stripe_end; FLUSH SHALL wait at most FLUSH_MAX cycles, then enter REPORT with o_res_timeout=1.
REQ-026 SHALL in REPORT pulse o_res_valid for 1 cycle with o_res_stripe=stripe, o_res_end_pos=base+i_end_position captured at stripe_end (mod 1024), and o_res_score=the captured score; on timeout, end_pos=SEQ_LEN-1 and score=0.
REQ-027 SHALL update base to min(base+i_start_position, SEQ_LEN-1) in REPORT; on timeout, base SHALL remain unchanged.
REQ-028 SHALL replace the best registers only when o_res_score > o_best_score (strict); ties SHALL keep the earlier stripe.
REQ-029 SHALL from REPORT go to LOAD_B with stripe+1, or to DONE after stripe NUM_STRIPES-1.
REQ-030 SHALL pulse o_done in DONE for 1 cycle, then return to IDLE with the best registers held until the next i_go.
REQ-031 SHALL hold o_busy=1 in every state except IDLE.
REQ-032 SHALL treat i_stripe_end arriving in the same cycle as the final address issue per REQ-024 (no FLUSH); it SHALL ignore i_stripe_end in IDLE, LOAD_B, WAIT_B, REPORT and DONE.

Reset
REQ-033 SHALL on i_rst=1, at any time including mid-stripe, immediately force state=IDLE and all outputs, counters, base and best registers to 0.
REQ-034 SHALL resume operation on the first rising edge after i_rst deasserts, waiting in IDLE for i_go.

Verification
REQ-035 SHALL be verified with NUM_STRIPES=2, PE returning start_position=100 and end_position=40 at stripe 0 -> stripe 1 streams from a_addr 100, and the stripe-0 result end_pos=40.
REQ-036 SHALL be verified with stripe scores 50 then 50 -> best_stripe=0, best_score=50; scores 50 then 51 -> best_stripe=1.
REQ-037 SHALL be verified with no i_stripe_end from the PE -> address 1023 issued, FLUSH_MAX cycles elapse, then o_res_timeout=1, score=0 and base unchanged.
REQ-038 SHALL be verified with i_rst asserted during STREAM -> o_start, o_busy and o_best_* equal 0 in the same cycle; a new i_go restarts at stripe 0, base 0.
REQ-039 SHALL be verified with i_go pulsed while busy -> no effect; o_done pulses exactly once after NUM_STRIPES results.
REQ-040 SHALL be verified at each stripe boundary -> o_start low for at least 2 cycles, and o_B equal to the B memory row for that stripe throughout STREAM.
